tdm_mux8_serializer: RTL and testbench

- 8-channel time-division multiplexer/serializer. It is the transmit end that feeds the team's 1-to-8 demux tree.
- On a load request it captures eight parallel channel words, then emits one word per enabled cycle on a single output.
- It drives the s0/s1/s2 select lines so the downstream demux routes slot k to its output yk.
- Sits between parallel channel sources and the shared serial link/demux.

---
 rtl/tdm_mux8_serializer.sv | 145 ++++++++++++++
 tb/tb_tdm_mux8_serializer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_mux8_serializer.sv
// 8-channel TDM serializer: captures eight channel words on load and emits one per enabled
// cycle, driving active-low demux selects coherent with the registered output word.
module tdm_mux8_serializer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    output logic [WIDTH-1:0] q,
    output logic             s0,
    output logic             s1,
    output logic             s2,
    output logic [2:0]       slot,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] d_arr [8];
    logic [WIDTH-1:0] cap_q [8];
    logic [WIDTH-1:0] cap_d [8];
    logic [WIDTH-1:0] q_q, q_d;
    logic [2:0]       slot_q, slot_d;
    logic [2:0]       slot_inc;
    logic [2:0]       sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             capture;

    assign d_arr[0] = d0;
    assign d_arr[1] = d1;
    assign d_arr[2] = d2;
    assign d_arr[3] = d3;
    assign d_arr[4] = d4;
    assign d_arr[5] = d5;
    assign d_arr[6] = d6;
    assign d_arr[7] = d7;

    assign slot_inc = slot_q + 3'd1;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        slot_d  = slot_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        capture = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    capture = 1'b1;
                end
            end
            StShift: begin
                if (en) begin
                    if (slot_q == 3'd7) begin
                        done_d = 1'b1;
                        // Reload on the last slot chains frames without a gap cycle.
                        if (load) begin
                            capture = 1'b1;
                        end else begin
                            state_d = StIdle;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        slot_d = slot_inc;
                        q_d    = cap_q[slot_inc];
                        sel_d  = ~slot_inc;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Slot 0 is presented straight from the inputs so the first word has one cycle latency.
        if (capture) begin
            state_d = StShift;
            slot_d  = 3'd0;
            q_d     = d_arr[0];
            sel_d   = 3'b111;
            valid_d = 1'b1;
            busy_d  = 1'b1;
        end

        for (int i = 0; i < 8; i++) begin
            cap_d[i] = capture ? d_arr[i] : cap_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            q_q     <= '0;
            slot_q  <= 3'd0;
            sel_q   <= 3'b000;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                cap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            slot_q  <= slot_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < 8; i++) begin
                cap_q[i] <= cap_d[i];
            end
        end
    end

    assign q            = q_q;
    assign {s0, s1, s2} = sel_q;
    assign slot         = slot_q;
    assign valid        = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_tdm_mux8_serializer.sv
// Bench for tdm_mux8_serializer: a queue-of-slots reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_tdm_mux8_serializer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic         en;
    logic [W-1:0] d [8];
    logic [W-1:0] q;
    logic         s0, s1, s2;
    logic [2:0]   slot;
    logic         valid, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    tdm_mux8_serializer #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .en   (en),
        .d0   (d[0]),
        .d1   (d[1]),
        .d2   (d[2]),
        .d3   (d[3]),
        .d4   (d[4]),
        .d5   (d[5]),
        .d6   (d[6]),
        .d7   (d[7]),
        .q    (q),
        .s0   (s0),
        .s1   (s1),
        .s2   (s2),
        .slot (slot),
        .valid(valid),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    // Reference model: an accepted load queues eight (word, slot) entries; each enabled cycle
    // consumes the head. The head is what the outputs show; an empty queue holds the last view.
    typedef struct packed {
        logic [W-1:0] w;
        logic [2:0]   s;
    } ent_t;

    ent_t         mq[$];
    logic         m_live = 1'b0;
    logic         m_done;
    logic [W-1:0] h_q;
    logic [2:0]   h_slot;
    logic [2:0]   h_sel;

    task automatic model_step();
        logic acc;
        ent_t e;
        m_live = 1'b1;
        if (rst) begin
            mq.delete();
            m_done = 1'b0;
            h_q    = '0;
            h_slot = 3'd0;
            h_sel  = 3'b000;
        end else begin
            acc    = load && (mq.size() == 0 || (mq.size() == 1 && en));
            m_done = 1'b0;
            if (en && mq.size() > 0) begin
                if (mq.size() == 1) m_done = 1'b1;
                void'(mq.pop_front());
            end
            if (acc) begin
                for (int i = 0; i < 8; i++) begin
                    e.w = d[i];
                    e.s = 3'(i);
                    mq.push_back(e);
                end
            end
            if (mq.size() > 0) begin
                h_q    = mq[0].w;
                h_slot = mq[0].s;
                h_sel  = ~mq[0].s;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("model.valid", int'(valid), int'(mq.size() > 0));
            chk("model.busy", int'(busy), int'(mq.size() > 0));
            chk("model.done", int'(done), int'(m_done));
            chk("model.q", int'(q), int'(h_q));
            chk("model.slot", int'(slot), int'(h_slot));
            chk("model.sel", int'({s0, s1, s2}), int'(h_sel));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_d(input logic [W-1:0] base);
        for (int i = 0; i < 8; i++) d[i] = base + W'(i);
    endtask

    int cnt;
    int dones;

    initial begin
        rst  = 1'b1;
        load = 1'b1;
        en   = 1'b1;
        set_d(4'h1);
        tick();
        tick();
        chk("rst.q", int'(q), 0);
        chk("rst.valid", int'(valid), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.sel", int'({s0, s1, s2}), 0);
        chk("rst.slot", int'(slot), 0);
        rst  = 1'b0;
        load = 1'b0;
        tick();
        chk("idle.valid", int'(valid), 0);

        // Basic frame
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("basic.first_q", int'(q), 1);
        chk("basic.first_sel", int'({s0, s1, s2}), 3'b111);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("basic.q", int'(q), k + 1);
            chk("basic.slot", int'(slot), k);
        end
        chk("basic.last_sel", int'({s0, s1, s2}), 3'b000);
        tick();
        chk("basic.done", int'(done), 1);
        chk("basic.end_valid", int'(valid), 0);
        tick();
        chk("basic.done_once", int'(done), 0);

        // Stall at slot 3
        load = 1'b1;
        tick();
        load = 1'b0;
        cnt  = 1;
        repeat (3) begin
            tick();
            cnt++;
        end
        en = 1'b0;
        repeat (3) begin
            tick();
            cnt++;
            chk("stall.q", int'(q), 4);
            chk("stall.sel", int'({s0, s1, s2}), 3'b100);
        end
        en = 1'b1;
        for (int b = 0; b < 20 && valid; b++) begin
            tick();
            if (valid) cnt++;
        end
        chk("stall.length", cnt, 11);
        tick();

        // Ignored load mid-frame
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        chk("ign.slot2_q", int'(q), 3);
        set_d(4'hF);
        for (int i = 0; i < 8; i++) d[i] = 4'hF;
        load = 1'b1;
        tick();
        load  = 1'b0;
        dones = 0;
        chk("ign.q_continues", int'(q), 4);
        chk("ign.slot", int'(slot), 3);
        for (int b = 0; b < 12; b++) begin
            tick();
            if (done) dones++;
        end
        chk("ign.done_count", dones, 1);

        // Back-to-back frames
        set_d(4'h1);
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (7) tick();
        chk("b2b.slot7_q", int'(q), 8);
        for (int i = 0; i < 8; i++) d[i] = 4'hA + W'(i);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("b2b.q", int'(q), 4'hA);
        chk("b2b.slot", int'(slot), 0);
        chk("b2b.valid", int'(valid), 1);
        chk("b2b.done", int'(done), 1);
        tick();
        chk("b2b.q1", int'(q), 4'hB);
        repeat (8) tick();
        chk("b2b.end_valid", int'(valid), 0);
        tick();

        // Reset mid-frame
        set_d(4'h3);
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        chk("mid.slot4", int'(slot), 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid.valid", int'(valid), 0);
        chk("mid.busy", int'(busy), 0);
        chk("mid.q", int'(q), 0);
        chk("mid.done", int'(done), 0);
        tick();
        chk("mid.no_done", int'(done), 0);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("mid.restart_q", int'(q), 3);
        chk("mid.restart_slot", int'(slot), 0);
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
